// File: rtl/scpu_pkg.sv
// Shared scpu constants: PC width and run-controller FSM state encodings.
// Pure definitions; no latency or flow control involved.
package scpu_pkg;

  localparam int PC_W    = 4;
  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 3'd1;
  localparam logic [STATE_W-1:0] ST_HALT = 3'd2;
  localparam logic [STATE_W-1:0] ST_STEP = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE = 3'd4;

endpackage

// File: rtl/run_controller_if.sv
// Run-control bundle: debugger commands and PC/breakpoint in, commit status out.
// Master issues commands and supplies the PC; slave (run_controller) reports status.
interface run_controller_if
  import scpu_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int PC_W  = scpu_pkg::PC_W
) ();

  logic               start;
  logic               stop;
  logic               step_req;
  logic [PC_W-1:0]    pc_in;
  logic               bp_valid;
  logic [PC_W-1:0]    bp_addr;
  logic               cpu_en;
  logic [STATE_W-1:0] state;
  logic               step_ack;
  logic               bp_hit_flag;
  logic               done;
  logic [CNT_W-1:0]   retired;

  modport master (
    output start, stop, step_req, pc_in, bp_valid, bp_addr,
    input  cpu_en, state, step_ack, bp_hit_flag, done, retired
  );

  modport slave (
    input  start, stop, step_req, pc_in, bp_valid, bp_addr,
    output cpu_en, state, step_ack, bp_hit_flag, done, retired
  );

endinterface

// File: rtl/retire_counter.sv
// Wrapping commit counter; increments on the edge after each enabled cycle.
// No backpressure: en is sampled every cycle.
module retire_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (en)
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/run_controller.sv
// Run/halt/step FSM gating CPU commits; cpu_en is combinational, status registered.
// Breakpoints only with RUN_CTRL_BREAKPOINT_EN defined; commands are single-cycle pulses, never stalled.
module run_controller
  import scpu_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int PC_W  = scpu_pkg::PC_W
) (
  input logic             clk,
  input logic             rst,
  run_controller_if.slave bus
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic               cpu_en;
  logic               prev_en;
  logic               self_loop;
  logic               bp_hit;
  logic               bp_flag_q;
  logic               step_ack_q;
  logic [PC_W-1:0]    pc_prev;
  logic [CNT_W-1:0]   retired;

`ifdef RUN_CTRL_BREAKPOINT_EN
  logic bp_skip;

  // bp_skip lets the instruction we halted on execute once after resuming.
  assign bp_hit = (state_q == ST_RUN) & bus.bp_valid & (bus.pc_in == bus.bp_addr) & ~bp_skip;

  always_ff @(posedge clk) begin
    if (rst) begin
      bp_skip   <= 1'b0;
      bp_flag_q <= 1'b0;
    end else begin
      if (state_q == ST_HALT && state_d == ST_RUN)
        bp_skip <= 1'b1;
      else if (state_q == ST_RUN && cpu_en)
        bp_skip <= 1'b0;

      if (bp_hit)
        bp_flag_q <= 1'b1;
      else if (state_q == ST_HALT && state_d != ST_HALT)
        bp_flag_q <= 1'b0;
    end
  end
`else
  assign bp_hit    = 1'b0;
  assign bp_flag_q = 1'b0;
  wire unused_bp = &{1'b0, bus.bp_valid, bus.bp_addr};
`endif

  // A branch-to-self right after a commit marks the program as finished.
  assign self_loop = (state_q == ST_RUN) & prev_en & (bus.pc_in == pc_prev);
  assign cpu_en    = ((state_q == ST_RUN) & ~bp_hit & ~self_loop) | (state_q == ST_STEP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop)
          state_d = ST_RUN;
        else if (bus.step_req && !bus.start)
          state_d = ST_STEP;
      end
      ST_RUN: begin
        if (bp_hit || bus.stop)
          state_d = ST_HALT;
        else if (self_loop)
          state_d = ST_DONE;
      end
      ST_HALT: begin
        if (bus.start)
          state_d = ST_RUN;
        else if (bus.step_req)
          state_d = ST_STEP;
      end
      ST_STEP: state_d = ST_HALT;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      prev_en    <= 1'b0;
      pc_prev    <= '0;
      step_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_en    <= cpu_en;
      step_ack_q <= (state_q == ST_STEP);
      if (cpu_en)
        pc_prev <= bus.pc_in;
    end
  end

  retire_counter #(.CNT_W(CNT_W)) u_retire (
    .clk   (clk),
    .rst   (rst),
    .en    (cpu_en),
    .count (retired)
  );

  assign bus.cpu_en      = cpu_en;
  assign bus.state       = state_q;
  assign bus.step_ack    = step_ack_q;
  assign bus.bp_hit_flag = bp_flag_q;
  assign bus.done        = (state_q == ST_DONE);
  assign bus.retired     = retired;

endmodule
